aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES-128 encryption core controller: accepts one plaintext/key pair via valid/ready,
//  sequences the shared one-round datapath (sub_bytes -> shift_rows -> mix_columns -> add-round-key)
//  for NR rounds, and holds the ciphertext until consumed. Includes on-the-fly key expansion.
//  Sits between the host/RISC-V bus adapter and the combinational round primitives.
// PARAMETERS
//  NR      10   number of AES rounds; only 10 (AES-128) is supported, checked by elaboration assert
//  DATA_W  128  block and key width; fixed at 128
// PORTS
//  clk        in   1    system clock
//  rst        in   1    synchronous active-high reset
//  in_valid   in   1    plaintext+key presented
//  in_ready   out  1    core can accept a block (IDLE only)
//  in_data    in   128  plaintext; byte0 = [127:120], column-major per FIPS-197
//  in_key     in   128  cipher key, same byte order
//  out_valid  out  1    ciphertext valid, held until accepted
//  out_ready  in   1    consumer accepts ciphertext
//  out_data   out  128  ciphertext, same byte order
//  busy       out  1    high in ROUND or DONE
//  round_idx  out  4    current round number 0..NR (debug/status)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - FSM: IDLE -> ROUND -> DONE -> IDLE.
//  - Reset values: state, key, out_data = 0; round_idx = 0; rcon = 8'h01; FSM = IDLE;
//    in_ready = 1, out_valid = 0, busy = 0.
//  - IDLE: in_ready = 1. On in_valid && in_ready at edge T:
//    state <= in_data ^ in_key; key <= in_key; round_idx <= 1; rcon <= 8'h01; go to ROUND.
//  - ROUND (round_idx r = 1..NR): each cycle, key_next = expand(key, rcon), then
//    state <= ARK(MC(SR(SB(state))), key_next), with MC bypassed when r == NR.
//    Also key <= key_next and rcon <= xtime(rcon) (0x80 -> 0x1b).
//    If r < NR: round_idx <= r+1. If r == NR: go to DONE.
//  - Latency: accept at edge T -> out_valid high after edge T+NR (10 cycles). Exactly one round per cycle.
//  - DONE: out_valid = 1; out_data = state, registered and stable while out_valid && !out_ready.
//    On out_ready, go to IDLE and set out_valid <= 0.
//  - No same-cycle turnaround: in_ready = 0 in DONE. Back-to-back blocks take NR+2 cycles each.
//  - in_valid while busy is ignored: no capture and no state corruption.
//  - in_data/in_key are sampled only on the accept edge, so later changes have no effect.
//  - out_ready while !out_valid is ignored.
//  - rst asserted mid-ROUND or in DONE: next edge returns to reset values.
//    The in-flight block is discarded and no out_valid pulse is produced.
//  - round_idx: 0 in IDLE, r during ROUND, NR in DONE.
//  - No combinational path from in_* to out_*. in_ready and out_valid decode from FSM registers only.
// STRUCTURE
//  - Shared package aes_pkg: state_t enum {IDLE, ROUND, DONE}; NR_AES128 = 10; RCON_INIT = 8'h01;
//    function xtime(byte); and typedef logic [127:0] block_t.
//  - Sub-module aes_key_step: combinational expansion of one round key.
//    Ports: key_in, rcon -> key_out (RotWord, SubWord via 4 s_box instances, XOR chain).
//  - Existing combinational sub_bytes, shift_rows and mix_columns are instantiated once.
//    A final-round mux selects SR output in place of the MC output.
// TESTING
//  1. FIPS-197 C.1: key 000102..0e0f, pt 00112233445566778899aabbccddeeff
//     -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
//  2. FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> 3925841d02dc09fbdc118597196a0b32. Round-1 internal key = a0fafe1788542cb123a339392a6c7605.
//  3. Backpressure: hold out_ready = 0 for 20 cycles after out_valid.
//     -> out_data stable, in_ready = 0 throughout. Then pulse out_ready -> in_ready = 1 the next cycle.
//  4. Busy rejection: keep in_valid = 1 with changing data during ROUND.
//     -> ciphertext still equals the accepted vector and in_ready = 0 for all 11 busy cycles.
//  5. Reset at round_idx = 5: assert rst 1 cycle.
//     -> out_valid never asserts, round_idx = 0, and in_ready = 1 after the edge.
//     A new C.1 block then yields the correct ciphertext.
//  6. Back-to-back: two blocks with out_ready tied 1 -> both correct; accepts 12 cycles apart; rcon restarts at 01.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-128 types, constants and GF(2^8) helpers.
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [127:0] block_t;

    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse as x^254 (product of x^2 .. x^128), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module : aes_key_step
// Brief  : One AES-128 key-schedule step: round key i -> round key i+1.
// Revision: 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  block_t     key_in,
    input  logic [7:0] rcon,
    output block_t     key_out
);
    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = key_in[127:96];
    assign w_w1  = key_in[95:64];
    assign w_w2  = key_in[63:32];
    assign w_w3  = key_in[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        s_box u_s_box (
            .i_byte (w_rot[8*i +: 8]),
            .o_byte (w_sub[8*i +: 8])
        );
    end

    assign w_temp  = w_sub ^ {rcon, 24'h000000};
    assign w_n0    = w_w0 ^ w_temp;
    assign w_n1    = w_w1 ^ w_n0;
    assign w_n2    = w_w2 ^ w_n1;
    assign w_n3    = w_w3 ^ w_n2;
    assign key_out = {w_n0, w_n1, w_n2, w_n3};
endmodule
`default_nettype wire

// File: rtl/aes_round_prims.sv
`default_nettype none
// ============================================================================
// Module : s_box / sub_bytes / shift_rows / mix_columns
// Brief  : Combinational AES round primitives, byte0 = [127:120], column-major.
// Revision: 1.0 - initial release
// ============================================================================
module s_box
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    assign o_byte = sbox(i_byte);
endmodule

module sub_bytes
    import aes_pkg::*;
(
    input  block_t i_block,
    output block_t o_block
);
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        s_box u_s_box (
            .i_byte (i_block[8*i +: 8]),
            .o_byte (o_block[8*i +: 8])
        );
    end
endmodule

module shift_rows
    import aes_pkg::*;
(
    input  block_t i_block,
    output block_t o_block
);
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_block[127 - 8*(r + 4*c) -: 8] =
                   i_block[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        end
    end
endmodule

module mix_columns
    import aes_pkg::*;
(
    input  block_t i_block,
    output block_t o_block
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] w_col;
        logic [7:0]  w_a0, w_a1, w_a2, w_a3;
        assign w_col = i_block[127 - 32*c -: 32];
        assign w_a0  = w_col[31:24];
        assign w_a1  = w_col[23:16];
        assign w_a2  = w_col[15:8];
        assign w_a3  = w_col[7:0];
        assign o_block[127 - 32*c -: 32] = {
            xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
            xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
        };
    end
endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aes_round_ctrl
// Brief  : Iterative AES-128 encryptor, one round per cycle, on-the-fly keys.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [3:0]        round_idx
);
    if (NR != NR_AES128 || DATA_W != 128) begin : g_param_check
        $error("aes_round_ctrl supports only NR=10 and DATA_W=128");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t     fsm_q, fsm_d;
    block_t     state_q, state_d;
    block_t     key_q, key_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;

    block_t w_key_next, w_sb, w_sr, w_mc, w_round_out;

    aes_key_step u_key_step (
        .key_in  (key_q),
        .rcon    (rcon_q),
        .key_out (w_key_next)
    );

    sub_bytes   u_sub_bytes   (.i_block(state_q), .o_block(w_sb));
    shift_rows  u_shift_rows  (.i_block(w_sb),    .o_block(w_sr));
    mix_columns u_mix_columns (.i_block(w_sr),    .o_block(w_mc));

    // The final round skips MixColumns.
    assign w_round_out = ((round_q == LAST_ROUND) ? w_sr : w_mc) ^ w_key_next;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ in_key;
                    key_d   = in_key;
                    round_d = 4'd1;
                    rcon_d  = RCON_INIT;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = w_round_out;
                key_d   = w_key_next;
                rcon_d  = xtime(rcon_q);
                if (round_q == LAST_ROUND) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= 4'd0;
            rcon_q  <= RCON_INIT;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign out_data  = state_q;
    assign round_idx = round_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_round_ctrl
// Brief  : Self-checking bench for aes_round_ctrl against a table-driven AES model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .DATA_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    // GF(2^8) via exp/log tables over generator 3.
    logic [7:0] g_exp [256];
    int         g_log [256];
    logic [7:0] m_sbox [256];

    task automatic build_tables();
        logic [8:0] e;
        logic [7:0] inv;
        logic [7:0] cst;
        logic [7:0] s;
        e = 9'd1;
        for (int i = 0; i < 255; i++) begin
            g_exp[i]      = e[7:0];
            g_log[e[7:0]] = i;
            e = {e[7:0], 1'b0} ^ {1'b0, e[7:0]};
            if (e[8]) e = e ^ 9'h11b;
        end
        g_exp[255] = 8'h01;
        g_log[0]   = 0;
        cst = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : g_exp[(255 - g_log[a]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8]
                     ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ cst[b];
            m_sbox[a] = s;
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return g_exp[(g_log[a] + g_log[b]) % 255];
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = m_sbox[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++)
                        t[j] = gmul(8'h02, s[4*c + j]) ^ gmul(8'h03, s[4*c + (j+1)%4])
                             ^ s[4*c + (j+2)%4] ^ s[4*c + (j+3)%4];
                    for (int j = 0; j < 4; j++) s[4*c + j] = t[j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block, wait (bounded) for in_ready, take the accept edge.
    task automatic present(input string tag, input logic [127:0] pt, input logic [127:0] k);
        int n;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = k;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_round1"}, 128'(round_idx), 128'd1);
    endtask

    task automatic wait_out(input string tag, input int start);
        int lat;
        lat = start;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd10);
        chk({tag, "_round_done"}, 128'(round_idx), 128'd10);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 128'(in_ready), 128'd1);
        chk({tag, "_valid_after"}, 128'(out_valid), 128'd0);
        chk({tag, "_round_idle"}, 128'(round_idx), 128'd0);
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp);
        present(tag, pt, k);
        wait_out(tag, 0);
        chk({tag, "_ct"}, out_data, exp);
        consume(tag);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

    logic [127:0] pa, ka, pb, kb, ea, eb;
    logic [127:0] res [2];
    int           acc_c [2];
    int           na, got;
    logic         acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_round",     128'(round_idx), 128'd0);
        chk("rst_out_data",  out_data,        128'd0);
        rst = 1'b0;

        // FIPS-197 C.1
        run_block("c1", C1_PT, C1_KEY, C1_CT);

        // FIPS-197 App.B with round-1 key probe
        present("appb", B_PT, B_KEY);
        tick();
        chk("appb_rk1", dut.key_q, B_RK1);
        wait_out("appb", 1);
        chk("appb_ct", out_data, B_CT);
        consume("appb");

        // out_ready while idle must do nothing
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_oready_valid", 128'(out_valid), 128'd0);
            chk("idle_oready_ready", 128'(in_ready),  128'd1);
        end
        out_ready = 1'b0;

        // Backpressure: hold the result for 20 cycles
        present("bp", C1_PT, C1_KEY);
        wait_out("bp", 0);
        for (int i = 0; i < 20; i++) begin
            chk("bp_data",  out_data,          C1_CT);
            chk("bp_ready", 128'(in_ready),    128'd0);
            chk("bp_valid", 128'(out_valid),   128'd1);
            tick();
        end
        consume("bp");

        // Busy rejection: in_valid held with changing data while busy
        present("busy", B_PT, B_KEY);
        in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            chk("busy_in_ready", 128'(in_ready), 128'd0);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        chk("busy_valid", 128'(out_valid), 128'd1);
        chk("busy_ct", out_data, B_CT);
        consume("busy");

        // Reset in the middle of round 5
        present("mid_rst", C1_PT, C1_KEY);
        for (int i = 0; i < 10 && round_idx != 4'd5; i++) tick();
        chk("mid_rst_at5", 128'(round_idx), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_round", 128'(round_idx), 128'd0);
        chk("mid_rst_ready", 128'(in_ready),  128'd1);
        chk("mid_rst_busy",  128'(busy),      128'd0);
        chk("mid_rst_data",  out_data,        128'd0);
        for (int i = 0; i < 15; i++) begin
            chk("mid_rst_no_valid", 128'(out_valid), 128'd0);
            tick();
        end
        run_block("post_rst", C1_PT, C1_KEY, C1_CT);

        // Random vectors against the model
        for (int n = 0; n < 4; n++) begin
            pa = {$urandom, $urandom, $urandom, $urandom};
            ka = {$urandom, $urandom, $urandom, $urandom};
            run_block("rand", pa, ka, ref_aes(pa, ka));
        end

        // Back-to-back with out_ready tied high
        pa = {$urandom, $urandom, $urandom, $urandom};
        ka = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        ea = ref_aes(pa, ka);
        eb = ref_aes(pb, kb);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pa;
        in_key    = ka;
        na = 0; got = 0;
        acc_c[0] = 0; acc_c[1] = 0;
        res[0] = '0; res[1] = '0;
        for (int c = 0; c < 80 && got < 2; c++) begin
            acc = in_ready && in_valid;
            if (acc && na < 2) begin
                acc_c[na] = c;
                na++;
            end
            if (out_valid) begin
                res[got] = out_data;
                got++;
            end
            tick();
            if (acc) begin
                if (na == 1) begin
                    in_data = pb;
                    in_key  = kb;
                end else begin
                    in_valid = 1'b0;
                    chk("b2b_rcon_restart", 128'(dut.rcon_q), 128'h01);
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_count", 128'(got), 128'd2);
        chk("b2b_ct_a", res[0], ea);
        chk("b2b_ct_b", res[1], eb);
        chk("b2b_spacing", 128'(acc_c[1] - acc_c[0]), 128'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
